multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Control unit for the team's multicycle ARM-subset datapath.
- Decodes the latched instruction fields and sequences the datapath through fetch/decode/execute/writeback states.
- Owns the NZCV status register and the condition-check logic that gates all architectural writes.
- Drives every datapath select/enable; takes the instruction fields and the ALU flags back from the datapath.

Parameters:
- FLAGS_RST, 4'b0000, reset value of the stored NZCV register, ordered {N,Z,C,V}.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  write enables
- AdrSrc  out  1  memory address select: 0=PC, 1=Result
- ALUSrcA  out  1  ALU source A: 0=register A, 1=PC
- ALUSrcB  out  2  ALU source B: 00=WriteData, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- RegSrc  out  2  [0]=1 selects R15 as ra1 (branch); [1]=1 selects Rd as ra2 (memory op)
- ImmSrc  out  2  equals Op
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- Illegal  out  1  high while in UNKNOWN

Behaviour:
- Reset: when reset==0 at a clk edge: state<=FETCH, flags<=FLAGS_RST, CondExR<=0. While reset==0, PCWrite/MemWrite/RegWrite/IRWrite are forced 0. Other outputs decode combinationally from state.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR if Op=01; BRANCH if Op=10; EXECUTER if Op=00 and Funct[5]=0; EXECUTEI if Op=00 and Funct[5]=1; UNKNOWN if Op=11 or DP cmd unsupported.
  - MEMADR -> MEMREAD if Funct[0]=1, else MEMWR.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI -> ALUWB, or -> FETCH for a no-write command (optional feature).
  - MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN -> FETCH.
- Per-state outputs (unlisted selects = 0, ALUControl = ADD):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode when ALUOp=1, on Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; anything else is unsupported.
- RegSrc and ImmSrc are driven from Op in every state.
- Flag write enables: FlagW[1] (NZ) = ALUOp & Funct[0]. FlagW[0] (CV) = ALUOp & Funct[0] & (ADD|SUB).
- Condition codes: Cond 0000..1101 per standard ARM (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE); 1110 = always; 1111 = never.
- CondEx timing: CondEx is evaluated from the stored flags and registered as CondExR at the DECODE->next edge. CondExR is held until the next DECODE, so a flag update in EXECUTE does not affect the same instruction's writeback.
- Gating: PCS = Branch | (RegW & Rd==4'hF).
  - PCWrite = NextPC | (PCS & CondExR).
  - RegWrite = RegW & CondExR.
  - MemWrite = MemW & CondExR.
  - Flag bits load ALUFlags at the end of the EXECUTE state when FlagW & CondExR.
- Latency, FETCH to next FETCH: LDR 5 cycles, STR/DP 4, B 3, illegal 3.
- Failed condition: state sequence unchanged; only the enables are suppressed.

Optional Feature:
- Macro: MULTICYCLE_CTRL_CMP_EN.
- Defined: Funct[4:1]=1010 with Funct[0]=1 (CMP) is supported. It issues SUB in EXECUTER/EXECUTEI, writes all four flags (if CondExR), then goes directly to FETCH with no RegWrite.
- Undefined: CMP decodes as unsupported -> UNKNOWN, Illegal=1 for one cycle, no flag write.

Test Plan:
- Release reset (1->0 held 2 cycles, then 1) -> first cycle FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00; flags=0000.
- 0xE2821005 (ADD R1,R2,#5) -> FETCH,DECODE,EXECUTEI(ALUSrcB=01, ALUControl=00),ALUWB(RegWrite=1, ResultSrc=00),FETCH.
- 0xE2500000 (SUBS R0,R0,#0), ALUFlags=0100 in EXECUTEI -> flags=0100. Then 0x0A000001 (BEQ) -> BRANCH with PCWrite=1; 0x1A000001 (BNE) -> BRANCH with PCWrite=0.
- 0xE5903004 (LDR R3,[R0,#4]) -> MEMADR, MEMREAD(AdrSrc=1), MEMWB(RegWrite=1, ResultSrc=01), 5 cycles total.
- With Z=1, 0x15803004 (STRNE) -> MEMWR with MemWrite=0, AdrSrc=1, then FETCH. reset=0 asserted during MEMREAD -> next state FETCH, flags=0000, no RegWrite.
- 0xE3500000 (CMP R0,#0), ALUFlags=0110 -> with macro: ALUControl=01, flags=0110, RegWrite never 1, 3rd cycle returns to FETCH. Without macro: UNKNOWN, Illegal=1, flags unchanged.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle ARM-subset control FSM with NZCV flags and condition
//            gating. Optional CMP support under MULTICYCLE_CTRL_CMP_EN.
// Revision : 1.0
// ============================================================================
module multicycle_ctrl #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMREAD = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    state_t     r_state;
    logic [3:0] r_flags;
    logic       r_cond_ex;

    logic       w_next_pc;
    logic       w_ir_w;
    logic       w_reg_w;
    logic       w_mem_w;
    logic       w_branch;
    logic       w_alu_op;
    logic       w_pcs;
    logic       w_cond_ex;
    logic [1:0] w_flag_w;

    logic       w_cmd_add;
    logic       w_cmd_sub;
    logic       w_cmd_and;
    logic       w_cmd_orr;
    logic       w_cmd_cmp;
    logic       w_dp_ok;

    // Data-processing command decode on Funct[4:1]
    always_comb begin
        w_cmd_add = (Funct[4:1] == 4'b0100);
        w_cmd_sub = (Funct[4:1] == 4'b0010);
        w_cmd_and = (Funct[4:1] == 4'b0000);
        w_cmd_orr = (Funct[4:1] == 4'b1100);
`ifdef MULTICYCLE_CTRL_CMP_EN
        w_cmd_cmp = (Funct[4:1] == 4'b1010) & Funct[0];
`else
        w_cmd_cmp = 1'b0;
`endif
        w_dp_ok   = w_cmd_add | w_cmd_sub | w_cmd_and | w_cmd_orr | w_cmd_cmp;
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = r_flags;
        w_cond_ex    = 1'b0;
        case (Cond)
            4'b0000: w_cond_ex = z;
            4'b0001: w_cond_ex = ~z;
            4'b0010: w_cond_ex = c;
            4'b0011: w_cond_ex = ~c;
            4'b0100: w_cond_ex = n;
            4'b0101: w_cond_ex = ~n;
            4'b0110: w_cond_ex = v;
            4'b0111: w_cond_ex = ~v;
            4'b1000: w_cond_ex = c & ~z;
            4'b1001: w_cond_ex = ~c | z;
            4'b1010: w_cond_ex = (n == v);
            4'b1011: w_cond_ex = (n != v);
            4'b1100: w_cond_ex = ~z & (n == v);
            4'b1101: w_cond_ex = z | (n != v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Per-state control decode; ALUControl defaults to ADD outside execute
    always_comb begin
        w_next_pc = 1'b0;
        w_ir_w    = 1'b0;
        w_reg_w   = 1'b0;
        w_mem_w   = 1'b0;
        w_branch  = 1'b0;
        w_alu_op  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        Illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_w    = 1'b1;
                w_next_pc = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB   = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_reg_w   = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                w_mem_w   = 1'b1;
            end
            S_EXECR: begin
                w_alu_op  = 1'b1;
            end
            S_EXECI: begin
                ALUSrcB   = 2'b01;
                w_alu_op  = 1'b1;
            end
            S_ALUWB: begin
                w_reg_w   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_branch  = 1'b1;
            end
            S_UNKNOWN: begin
                Illegal   = 1'b1;
            end
            default: begin
                Illegal   = 1'b0;
            end
        endcase
    end

    always_comb begin
        ALUControl = 2'b00;
        if (w_alu_op) begin
            if (w_cmd_sub | w_cmd_cmp) begin
                ALUControl = 2'b01;
            end else if (w_cmd_and) begin
                ALUControl = 2'b10;
            end else if (w_cmd_orr) begin
                ALUControl = 2'b11;
            end else begin
                ALUControl = 2'b00;
            end
        end
    end

    always_comb begin
        w_flag_w[1] = w_alu_op & Funct[0];
        w_flag_w[0] = w_alu_op & Funct[0] & (w_cmd_add | w_cmd_sub | w_cmd_cmp);
    end

    // Architectural writes are gated by the condition latched in DECODE
    assign w_pcs    = w_branch | (w_reg_w & (Rd == 4'hF));
    assign PCWrite  = reset & (w_next_pc | (w_pcs & r_cond_ex));
    assign RegWrite = reset & w_reg_w & r_cond_ex;
    assign MemWrite = reset & w_mem_w & r_cond_ex;
    assign IRWrite  = reset & w_ir_w;
    assign RegSrc   = {(Op == 2'b01), (Op == 2'b10)};
    assign ImmSrc   = Op;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_flags   <= FLAGS_RST;
            r_cond_ex <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_cond_ex <= w_cond_ex;
                    case (Op)
                        2'b01:   r_state <= S_MEMADR;
                        2'b10:   r_state <= S_BRANCH;
                        2'b00: begin
                            if (!w_dp_ok) begin
                                r_state <= S_UNKNOWN;
                            end else if (Funct[5]) begin
                                r_state <= S_EXECI;
                            end else begin
                                r_state <= S_EXECR;
                            end
                        end
                        default: r_state <= S_UNKNOWN;
                    endcase
                end
                S_MEMADR: begin
                    r_state <= Funct[0] ? S_MEMREAD : S_MEMWR;
                end
                S_MEMREAD: begin
                    r_state <= S_MEMWB;
                end
                S_EXECR, S_EXECI: begin
                    r_state <= w_cmd_cmp ? S_FETCH : S_ALUWB;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase

            if (w_alu_op && r_cond_ex) begin
                if (w_flag_w[1]) begin
                    r_flags[3:2] <= ALUFlags[3:2];
                end
                if (w_flag_w[0]) begin
                    r_flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire
